// File: rtl/updown_mod_counter.sv
// Modulo up/down counter with trig start/stop, synchronous preload, wrap or saturate ends, and a tc pulse.
// Latency: all outputs registered, one cycle; no backpressure, one step per clock while running.
module updown_mod_counter #(
    parameter int WIDTH    = 6,
    parameter int MODULUS  = 21,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl,
    input  logic             trig,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    state_t           state;
    state_t           state_next;
    logic             trig_q;
    logic             trig_edge;
    logic             step;
    logic             terminal;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= 1'b0;
            state  <= STOPPED;
            count  <= '0;
            tc     <= 1'b0;
        end else begin
            trig_q <= trig;
            state  <= state_next;
            count  <= count_next;
            tc     <= tc_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        tc_next    = 1'b0;
        trig_edge  = trig & ~trig_q;
        // Range ends are the modulus limits, not the natural 2^WIDTH rollover.
        terminal   = ctrl ? (count == '0) : (count == TOP);
        step       = (state == RUNNING) && !load && !trig_edge;

        if (trig_edge) begin
            state_next = (state == RUNNING) ? STOPPED : RUNNING;
        end

        if (load) begin
            count_next = (load_val > TOP) ? TOP : load_val;
        end else if (step) begin
            if (terminal) begin
                tc_next = 1'b1;
                if (SATURATE != 0) begin
                    state_next = STOPPED;
                end else begin
                    count_next = ctrl ? TOP : '0;
                end
            end else begin
                count_next = ctrl ? (count - WIDTH'(1)) : (count + WIDTH'(1));
            end
        end
    end

    assign running = (state == RUNNING);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a wrapping instance and a saturating instance on shared stimulus.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       ctrl;
    logic       trig;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] count0, count1;
    logic       running0, running1;
    logic       tc0, tc1;

    int n_checks = 0;
    int n_fail   = 0;

    updown_mod_counter #(.WIDTH(6), .MODULUS(21), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .ctrl(ctrl), .trig(trig), .load(load),
        .load_val(load_val), .count(count0), .running(running0), .tc(tc0)
    );

    updown_mod_counter #(.WIDTH(6), .MODULUS(21), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .ctrl(ctrl), .trig(trig), .load(load),
        .load_val(load_val), .count(count1), .running(running1), .tc(tc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_wrap(input string tag, input int c, input int r, input int t);
        check({tag, ".count"}, 32'(count0), 32'(c));
        check({tag, ".running"}, 32'(running0), 32'(r));
        check({tag, ".tc"}, 32'(tc0), 32'(t));
    endtask

    task automatic check_sat(input string tag, input int c, input int r, input int t);
        check({tag, ".count"}, 32'(count1), 32'(c));
        check({tag, ".running"}, 32'(running1), 32'(r));
        check({tag, ".tc"}, 32'(tc1), 32'(t));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        ctrl     = 1'b0;
        trig     = 1'b0;
        load     = 1'b0;
        load_val = '0;
        repeat (3) tick();
        check_wrap("reset", 0, 0, 0);
        check_sat("reset_sat", 0, 0, 0);
        reset = 1'b1;
        tick();
        check_wrap("idle", 0, 0, 0);

        // Up count across the full range with a wrap.
        trig = 1'b1;
        tick();
        check_wrap("start_up", 0, 1, 0);
        trig = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_wrap($sformatf("up_%0d", i), i, 1, 0);
        end
        tick();
        check_wrap("wrap_up", 0, 1, 1);
        tick();
        check_wrap("after_wrap_up", 1, 1, 0);

        // Stop, reload zero, then count down through the bottom wrap.
        trig = 1'b1;
        tick();
        check_wrap("stop_freeze", 1, 0, 0);
        trig = 1'b0;
        load = 1'b1;
        load_val = 6'd0;
        tick();
        check_wrap("load0", 0, 0, 0);
        load = 1'b0;
        ctrl = 1'b1;
        trig = 1'b1;
        tick();
        check_wrap("start_down", 0, 1, 0);
        trig = 1'b0;
        tick();
        check_wrap("wrap_down", 20, 1, 1);
        for (int i = 19; i >= 15; i--) begin
            tick();
            check_wrap($sformatf("down_%0d", i), i, 1, 0);
        end
        ctrl = 1'b0;
        tick();
        check_wrap("dir_flip", 16, 1, 0);

        // Out-of-range load clamps; load beats step.
        load = 1'b1;
        load_val = 6'd63;
        tick();
        check_wrap("load_clamp", 20, 1, 0);
        load = 1'b0;
        tick();
        check_wrap("wrap_after_clamp", 0, 1, 1);
        load = 1'b1;
        load_val = 6'd5;
        trig = 1'b1;
        tick();
        check_wrap("load_and_stop", 5, 0, 0);
        load = 1'b0;
        trig = 1'b0;
        tick();
        check_wrap("stopped_hold", 5, 0, 0);

        // A held trig level gives a single start.
        load = 1'b1;
        load_val = 6'd0;
        tick();
        load = 1'b0;
        trig = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_wrap($sformatf("held_%0d", i), i, 1, 0);
        end
        trig = 1'b0;
        load = 1'b1;
        load_val = 6'd7;
        tick();
        check_wrap("load7_running", 7, 1, 0);
        load = 1'b0;
        trig = 1'b1;
        tick();
        check_wrap("stop_at_7", 7, 0, 0);
        trig = 1'b0;
        repeat (2) tick();
        check_wrap("frozen_7", 7, 0, 0);

        // Asynchronous reset between edges.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        check_wrap("pre_reset", 9, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        check_wrap("async_reset", 0, 0, 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        check_wrap("post_reset_idle", 0, 0, 0);

        // trig already high at release acts as a start edge.
        reset = 1'b0;
        trig = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_wrap("trig_high_release", 0, 1, 0);
        tick();
        check_wrap("trig_high_step", 1, 1, 0);
        trig = 1'b0;

        // Saturating instance: up block and down block.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ctrl = 1'b0;
        load = 1'b1;
        load_val = 6'd18;
        tick();
        check_sat("sat_load18", 18, 0, 0);
        load = 1'b0;
        trig = 1'b1;
        tick();
        check_sat("sat_start", 18, 1, 0);
        trig = 1'b0;
        tick();
        check_sat("sat_19", 19, 1, 0);
        tick();
        check_sat("sat_20", 20, 1, 0);
        tick();
        check_sat("sat_block_up", 20, 0, 1);
        tick();
        check_sat("sat_hold_up", 20, 0, 0);

        ctrl = 1'b1;
        load = 1'b1;
        load_val = 6'd1;
        tick();
        load = 1'b0;
        trig = 1'b1;
        tick();
        check_sat("sat_start_down", 1, 1, 0);
        trig = 1'b0;
        tick();
        check_sat("sat_0", 0, 1, 0);
        tick();
        check_sat("sat_block_down", 0, 0, 1);
        tick();
        check_sat("sat_hold_down", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
